// File: rtl/seq_symbol_emitter.sv
// seq_symbol_emitter: buffers 8-bit batches of four 2-bit symbols in a small
// FIFO and serialises them one symbol per output handshake, bits [1:0] first.
// tail_sym feeds the upstream generator's restricted-symbol input.
// Optional macro SEQ_EMIT_DUP_CHECK_EN enables the dup_cnt repeat counter;
// without it dup_cnt is tied to zero.
module seq_symbol_emitter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_seq,
    output logic             in_ready,
    output logic             out_valid,
    output logic [1:0]       out_sym,
    input  logic             out_ready,
    output logic [1:0]       tail_sym,
    output logic [1:0]       last_sym,
    output logic [LVL_W-1:0] level,
    input  logic             flush,
    output logic [7:0]       dup_cnt
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_EMIT  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [7:0]       sreg, sreg_nxt;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W-1:0] fifo_cnt;
    logic             fifo_full, fifo_has;
    logic             push, pop, out_hs;

    // FIFO occupancy and handshake qualifiers
    assign fifo_cnt  = wr_ptr - rd_ptr;
    assign fifo_full = (fifo_cnt == PTR_W'(DEPTH));
    assign fifo_has  = (fifo_cnt != '0);
    assign level     = LVL_W'(fifo_cnt);
    assign in_ready  = ~fifo_full & ~flush;
    assign push      = in_valid & in_ready;
    assign out_valid = (state == S_EMIT);
    assign out_sym   = 2'(sreg >> {idx, 1'b0});
    assign out_hs    = out_valid & out_ready;

    // Serializer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_EMPTY;
            idx   <= 2'd0;
            sreg  <= 8'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            sreg  <= sreg_nxt;
        end
    end

    // Serializer next state: load a batch when idle or back-to-back after symbol 3
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        sreg_nxt  = sreg;
        pop       = 1'b0;
        unique case (state)
            S_EMPTY: begin
                if (fifo_has) begin
                    pop       = 1'b1;
                    sreg_nxt  = mem[rd_ptr[AW-1:0]];
                    idx_nxt   = 2'd0;
                    state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (idx != 2'd3) begin
                        idx_nxt = idx + 2'd1;
                    end else if (fifo_has) begin
                        pop      = 1'b1;
                        sreg_nxt = mem[rd_ptr[AW-1:0]];
                        idx_nxt  = 2'd0;
                    end else begin
                        idx_nxt   = 2'd0;
                        state_nxt = S_EMPTY;
                    end
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
        if (flush) begin
            pop       = 1'b0;
            idx_nxt   = 2'd0;
            state_nxt = S_EMPTY;
        end
    end

    // FIFO storage; contents are qualified by the pointers so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_seq;
        end
    end

    // Pointers, tail and last symbol tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tail_sym <= 2'd0;
            last_sym <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                tail_sym <= in_seq[7:6];
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (out_hs && !flush) begin
                last_sym <= out_sym;
            end
        end
    end

`ifdef SEQ_EMIT_DUP_CHECK_EN
    logic [7:0] dup_q;

    // Count batches whose head repeats the previous batch's tail, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dup_q <= 8'd0;
        end else if (push && (in_seq[1:0] == tail_sym) && (dup_q != 8'hFF)) begin
            dup_q <= dup_q + 8'd1;
        end
    end

    assign dup_cnt = dup_q;
`else
    assign dup_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_seq_symbol_emitter.sv
// Scoreboard bench for seq_symbol_emitter: directed scenarios followed by
// randomized traffic checked against a symbol-queue reference model.
module tb_seq_symbol_emitter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [7:0]       in_seq;
    logic             in_ready;
    logic             out_valid;
    logic [1:0]       out_sym;
    logic             out_ready;
    logic [1:0]       tail_sym;
    logic [1:0]       last_sym;
    logic [LVL_W-1:0] level;
    logic             flush;
    logic [7:0]       dup_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: every accepted symbol in output order
    logic [1:0] exp_q[$];
    logic [1:0] exp_tail = 2'd0;
    logic [1:0] exp_last = 2'd0;
    int         exp_dup  = 0;

    seq_symbol_emitter #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_seq(in_seq),
        .in_ready(in_ready), .out_valid(out_valid), .out_sym(out_sym),
        .out_ready(out_ready), .tail_sym(tail_sym), .last_sym(last_sym),
        .level(level), .flush(flush), .dup_cnt(dup_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_tail = 2'd0;
        exp_last = 2'd0;
        exp_dup  = 0;
    endtask

    // One cycle of stimulus; books accepted batches into the model before the edge
    task automatic cyc(input logic v, input logic [7:0] s, input logic r, input logic f,
                       output logic acc);
        @(negedge clk);
        in_valid  = v;
        in_seq    = s;
        out_ready = r;
        flush     = f;
        #2;
        if (flush) exp_q.delete();
        acc = rst_n && in_valid && in_ready;
        if (acc) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(s[2*k +: 2]);
            if (s[1:0] == exp_tail && exp_dup < 255) exp_dup++;
            exp_tail = s[7:6];
        end
    endtask

    task automatic idle(input int n, input logic r);
        logic a;
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, r, 1'b0, a);
    endtask

    task automatic drain(input string nm);
        int  n = 0;
        logic a;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0, a);
            n++;
        end
        chk({nm, "_drain_done"}, 32'(n < 200), 32'd1);
        chk({nm, "_drain_level"}, 32'(level), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0; in_seq = 8'h00; out_ready = 1'b0; flush = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int exp_dup_dir();
`ifdef SEQ_EMIT_DUP_CHECK_EN
        return exp_dup;
`else
        return 0;
`endif
    endfunction

    // Monitor: pops the scoreboard on every output handshake and tracks side outputs
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            chk("tail_sym", 32'(tail_sym), 32'(exp_tail));
            chk("last_sym", 32'(last_sym), 32'(exp_last));
            chk("dup_cnt", 32'(dup_cnt), 32'(exp_dup_dir()));
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'(out_sym), 32'hFFFF_FFFF);
                end else begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    chk("out_sym", 32'(out_sym), 32'(e));
                    exp_last = e;
                end
            end
        end
    end

    initial begin
        logic       a;
        logic [1:0] held;
        logic [7:0] b[6];
        int         n;

        rst_n = 1'b0;
        in_valid = 1'b0; in_seq = 8'h00; out_ready = 1'b0; flush = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out_sym", 32'(out_sym), 32'd0);
        chk("rst_tail", 32'(tail_sym), 32'd0);
        chk("rst_last", 32'(last_sym), 32'd0);
        chk("rst_dup", 32'(dup_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single batch latency and ordering
        cyc(1'b1, 8'hE4, 1'b1, 1'b0, a);
        chk("t1_accept", 32'(a), 32'd1);
        idle(1, 1'b1);
        chk("t1_valid_n1", 32'(out_valid), 32'd0);
        idle(1, 1'b1);
        chk("t1_valid_n2", 32'(out_valid), 32'd1);
        chk("t1_first_sym", 32'(out_sym), 32'd0);
        idle(3, 1'b1);
        idle(1, 1'b1);
        chk("t1_valid_end", 32'(out_valid), 32'd0);
        chk("t1_level_end", 32'(level), 32'd0);
        chk("t1_tail", 32'(tail_sym), 32'd3);
        chk("t1_last", 32'(last_sym), 32'd3);

        // Back-to-back batches with no bubble
        do_reset();
        cyc(1'b1, 8'hE4, 1'b1, 1'b0, a);
        cyc(1'b1, 8'h1B, 1'b1, 1'b0, a);
        for (int i = 0; i < 8; i++) begin
            idle(1, 1'b1);
            chk("t2_no_bubble", 32'(out_valid), 32'd1);
        end
        idle(1, 1'b1);
        chk("t2_valid_end", 32'(out_valid), 32'd0);

        // Backpressure fills the FIFO
        do_reset();
        b[0] = 8'hE4; b[1] = 8'h1B;
        for (int i = 2; i < 6; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, b[i], 1'b0, 1'b0, a);
            chk("t3_accept", 32'(a), 32'(i < 5));
        end
        chk("t3_level_full", 32'(level), 32'(DEPTH));
        chk("t3_in_ready_full", 32'(in_ready), 32'd0);
        held = out_sym;
        chk("t3_head_sym", 32'(held), 32'(b[0][1:0]));
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, b[5], 1'b0, 1'b0, a);
            chk("t3_stalled", 32'(a), 32'd0);
            chk("t3_sym_stable", 32'(out_sym), 32'(held));
        end
        n = 0;
        a = 1'b0;
        while (!a && n < 20) begin
            cyc(1'b1, b[5], 1'b1, 1'b0, a);
            n++;
        end
        chk("t3_sixth_accepted", 32'(a), 32'd1);
        drain("t3");

        // Mid-batch flush with queued batches
        do_reset();
        cyc(1'b1, 8'hE4, 1'b0, 1'b0, a);
        cyc(1'b1, 8'hA5, 1'b0, 1'b0, a);
        cyc(1'b1, 8'hC3, 1'b0, 1'b0, a);
        idle(1, 1'b0);
        chk("t4_queued", 32'(level), 32'd2);
        idle(2, 1'b1);
        cyc(1'b1, 8'h4E, 1'b1, 1'b1, a);
        chk("t4_flush_in_ready", 32'(in_ready), 32'd0);
        chk("t4_flush_drop", 32'(a), 32'd0);
        idle(1, 1'b1);
        chk("t4_valid_after", 32'(out_valid), 32'd0);
        chk("t4_level_after", 32'(level), 32'd0);
        chk("t4_last_kept", 32'(last_sym), 32'd1);
        chk("t4_tail_kept", 32'(tail_sym), 32'd3);
        cyc(1'b1, 8'h1B, 1'b1, 1'b0, a);
        idle(1, 1'b1);
        idle(1, 1'b1);
        chk("t4_restart_sym0", 32'(out_sym), 32'd3);
        drain("t4");

        // Asynchronous reset mid-emit
        cyc(1'b1, 8'hE4, 1'b0, 1'b0, a);
        idle(2, 1'b0);
        chk("t5_pre_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_async_valid", 32'(out_valid), 32'd0);
        chk("t5_async_in_ready", 32'(in_ready), 32'd1);
        chk("t5_async_level", 32'(level), 32'd0);
        chk("t5_async_tail", 32'(tail_sym), 32'd0);
        chk("t5_async_sym", 32'(out_sym), 32'd0);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 1'b1);
        chk("t5_post_valid", 32'(out_valid), 32'd0);

        // Repeat counter across batch boundaries
        do_reset();
        cyc(1'b1, 8'h24, 1'b1, 1'b0, a);
        cyc(1'b1, 8'h1C, 1'b1, 1'b0, a);
        cyc(1'b1, 8'h39, 1'b1, 1'b0, a);
        idle(1, 1'b1);
`ifdef SEQ_EMIT_DUP_CHECK_EN
        chk("t6_dup_cnt", 32'(dup_cnt), 32'd2);
`else
        chk("t6_dup_cnt", 32'(dup_cnt), 32'd0);
`endif
        drain("t6");

        // Randomized traffic with varying backpressure and rare flushes
        for (int blk = 0; blk < 15; blk++) begin
            int rp;
            rp = int'($urandom_range(10, 95));
            for (int i = 0; i < 200; i++) begin
                cyc(1'($urandom_range(0, 9) < 6), 8'($urandom),
                    1'(int'($urandom_range(0, 99)) < rp),
                    1'($urandom_range(0, 99) < 2), a);
            end
        end
        drain("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
